// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants for the programmable counter family: default widths and
// the counting-mode encodings presented on mode_i.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 8;
    localparam int PRESC_W_DEFAULT       = 4;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    // Encoding 3 is reserved and is treated exactly like MODE_WRAP.
    localparam logic [1:0] MODE_RSVD    = 2'd3;

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Divides the enabled clock by (presc_i + 1) and emits a one-cycle tick.
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en_i     in   advance enable
//   clr_i    in   synchronous clear of the divide counter (wins over counting)
//   hold_i   in   freezes the divide counter and suppresses the tick
//   presc_i  in   divide select; tick every presc_i+1 enabled cycles
//   tick_o   out  combinational tick, high on the cycle pcnt reaches presc_i
// -----------------------------------------------------------------------------
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic               hold_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] pcnt_q;
    logic [PRESC_W-1:0] pcnt_d;
    logic               active;

    assign active = en_i && !hold_i;
    assign tick_o = active && (pcnt_q == presc_i);

    // If presc_i is lowered below the current pcnt, the count runs on and
    // wraps modulo 2^PRESC_W before it meets presc_i again.
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (tick_o) begin
            pcnt_d = '0;
        end else if (active) begin
            pcnt_d = pcnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/counter_prog.sv
// -----------------------------------------------------------------------------
// counter_prog
// Up/down counter with programmable upper bound and prescaler. Supports wrap,
// saturate and one-shot behaviour at the bound, a terminal-count pulse and a
// combinational compare output.
//
// Ports
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   en_i         in   count enable (gates the prescaler)
//   clear_i      in   sync clear of q, prescaler and done
//   load_i       in   sync load of d_i into q; clears prescaler and done
//   up_i         in   1 = count up, 0 = count down
//   mode_i       in   0 wrap, 1 saturate, 2 one-shot, 3 as wrap
//   presc_i      in   tick every presc_i+1 enabled cycles
//   max_val_i    in   upper count bound (lower bound fixed at 0)
//   d_i          in   parallel load value
//   cmp_val_i    in   compare value
//   q_o          out  registered count
//   tc_o         out  registered one-cycle terminal-count pulse
//   done_o       out  registered one-shot completion flag
//   cmp_match_o  out  combinational q_o == cmp_val_i
// -----------------------------------------------------------------------------
module counter_prog
    import counter_pkg::*;
#(
    parameter int WIDTH   = COUNTER_WIDTH_DEFAULT,
    parameter int PRESC_W = PRESC_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic               up_i,
    input  logic [1:0]         mode_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [WIDTH-1:0]   max_val_i,
    input  logic [WIDTH-1:0]   d_i,
    input  logic [WIDTH-1:0]   cmp_val_i,
    output logic [WIDTH-1:0]   q_o,
    output logic               tc_o,
    output logic               done_o,
    output logic               cmp_match_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;
    logic             done_q;
    logic             done_d;
    logic             tick;
    logic             at_bound;

    // done freezes the prescaler, so no tick can reach the count logic
    // once a one-shot has completed.
    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en_i),
        .clr_i   (clear_i || load_i),
        .hold_i  (done_q),
        .presc_i (presc_i),
        .tick_o  (tick)
    );

    // Counting up uses >= so a loaded value above the bound is still
    // treated as being at the bound.
    assign at_bound = up_i ? (q_q >= max_val_i) : (q_q == '0);

    always_comb begin
        q_d    = q_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (clear_i) begin
            q_d    = '0;
            done_d = 1'b0;
        end else if (load_i) begin
            q_d    = d_i;
            done_d = 1'b0;
        end else if (tick) begin
            if (!at_bound) begin
                q_d = up_i ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
            end else begin
                tc_d = 1'b1;
                case (mode_i)
                    MODE_SAT: begin
                        q_d = q_q;
                    end
                    MODE_ONESHOT: begin
                        q_d    = q_q;
                        done_d = 1'b1;
                    end
                    default: begin
                        q_d = up_i ? '0 : max_val_i;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign q_o         = q_q;
    assign tc_o        = tc_q;
    assign done_o      = done_q;
    assign cmp_match_o = (q_q == cmp_val_i);

endmodule
